// File: rtl/past_hist_pkg.sv
// Shared constants, types and helpers for the gated look-back history buffer.
// Default widths here describe the standard instance; modules carry their own parameters.
package past_hist_pkg;

  localparam int PKG_DATA_W = 4;
  localparam int PKG_DEPTH  = 16;

  typedef logic [PKG_DATA_W-1:0] data_t;

  localparam int          FILL_MAX = PKG_DEPTH;
  localparam int unsigned RST_PTR  = 0;
  localparam int unsigned RST_FILL = 0;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/past_hist_mem.sv
// History storage: DEPTH x DATA_W register array, one write port, one asynchronous read port.
// Contents are intentionally not reset; the owner masks reads by its fill level.
module past_hist_mem
  import past_hist_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = ptr_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Capture one sample into the addressed entry.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/past_history_buffer.sv
// Hardware $past(din, N, en): circular history of gated samples with runtime look-back N.
// Reads are combinational from registered state and masked by the fill level.
module past_history_buffer
  import past_hist_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic [PTR_W:0]    rd_ticks,
  output logic [DATA_W-1:0] past_out,
  output logic              past_valid,
  output logic              past_changed,
  output logic [PTR_W:0]    fill
);

  localparam logic [PTR_W:0]   FILL_FULL = DEPTH[PTR_W:0];
  localparam logic [PTR_W-1:0] PTR_INIT  = RST_PTR[PTR_W-1:0];
  localparam logic [PTR_W:0]   FILL_INIT = RST_FILL[PTR_W:0];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    fill_q, fill_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              write_en_s;
  logic [PTR_W-1:0]  rd_idx_s;
  logic [DATA_W-1:0] rd_data_s;
  logic              valid_s;

  assign write_en_s = en & ~rst & ~clr;

  // Next-state for pointer, fill level and most recent sample; clr flushes ahead of capture.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    last_d   = last_q;
    if (clr) begin
      wr_ptr_d = PTR_INIT;
      fill_d   = FILL_INIT;
    end else if (en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      last_d   = din;
      if (fill_q == FILL_FULL) begin
        fill_d = FILL_FULL;
      end else begin
        fill_d = fill_q + (PTR_W + 1)'(1);
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= PTR_INIT;
      fill_q   <= FILL_INIT;
      last_q   <= {DATA_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      last_q   <= last_d;
    end
  end

  // rd_ticks == DEPTH drops to 0 in the low bits, landing on wr_ptr: the oldest entry.
  assign rd_idx_s = wr_ptr_q - rd_ticks[PTR_W-1:0];

  past_hist_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (write_en_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (din),
    .raddr_i (rd_idx_s),
    .rdata_o (rd_data_s)
  );

  assign valid_s      = (rd_ticks != {(PTR_W + 1){1'b0}}) && (rd_ticks <= fill_q);
  assign past_valid   = valid_s;
  assign past_out     = valid_s ? rd_data_s : {DATA_W{1'b0}};
  assign past_changed = (fill_q != {(PTR_W + 1){1'b0}}) && (din != last_q);
  assign fill         = fill_q;

endmodule

// File: doc/past_history_buffer.md
Name: past_history_buffer

Overview:
- Synthesizable RTL equivalent of the gated `$past(sig, N, en)` system function.
- Captures `din` on every rising clock edge where `en` is high into a circular history buffer.
- Returns the value captured N gated ticks back, for a runtime-selectable N.
- Sits beside datapath blocks that need look-back values in hardware: checkers, edge or change detectors, and debug taps feeding the assertion benches.

Parameters:
- DATA_W, 4, width of the sampled signal.
- DEPTH, 16, number of history entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), write-pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous history flush; same effect as rst on state.
- en  in  1  gating enable; a sample is captured only on edges where en=1.
- din  in  DATA_W  signal being tracked.
- rd_ticks  in  PTR_W+1  look-back distance N; legal range 1..DEPTH.
- past_out  out  DATA_W  value of din at the N-th most recent gated edge.
- past_valid  out  1  high when 1 <= rd_ticks <= fill.
- past_changed  out  1  high when fill >= 1 and din != most recent captured value.
- fill  out  PTR_W+1  number of valid entries, saturating at DEPTH.

Behaviour:
- State: storage array mem[DEPTH], write pointer wr_ptr (PTR_W bits), fill counter (PTR_W+1 bits).
- Reset, on a rising edge with rst=1: wr_ptr=0, fill=0. mem is not reset.
  - All outputs are masked by fill, so after reset: past_out=0, past_valid=0, past_changed=0, fill=0.
- Capture, on a rising edge with en=1 and rst=0 and clr=0:
  - mem[wr_ptr] <= din.
  - wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
  - fill <= min(fill+1, DEPTH).
- Edges with en=0: no state change, and gated-tick counting pauses. N counts gated edges, not clock cycles.
- Wrap-around: once fill=DEPTH, each capture overwrites the oldest entry. fill stays at DEPTH.
- Read path is combinational from registered state, with zero added latency:
  - idx = (wr_ptr - rd_ticks) mod DEPTH.
  - past_out = mem[idx] when past_valid, else 0 (matches `$past` returning 0 before history exists).
- rd_ticks=0 or rd_ticks > fill: past_valid=0, past_out=0. Out-of-range values never read stale or unwritten storage.
- rd_ticks=DEPTH with fill=DEPTH: returns the oldest entry. This is the entry at wr_ptr, the next one to be overwritten.
- past_changed compares live din against mem[wr_ptr-1]. It is 0 when fill=0. It is independent of rd_ticks and en.
- Priority, highest first: rst, then clr, then en.
  - clr=1 with en=1 on the same edge: flush wins and din is not captured; fill=0 after the edge.
- Reset or clr in mid-stream: all history is discarded at once. The first capture afterwards lands at wr_ptr=0.
- Sampling semantics: a din change in the same timestep as the edge is seen with its pre-edge value. This matches `$sampled` / `$past`.
- Sample timing of the read: the value visible in the cycle after a gated edge with rd_ticks=1 is the din captured at that edge.
- Width rules: all pointer arithmetic is PTR_W bits with natural modulo wrap. fill and rd_ticks compares use PTR_W+1 bits unsigned.

Decomposition:
- Package past_hist_pkg holds:
  - Function ptr_w(depth), returning $clog2(depth).
  - Typedef data_t, a logic vector of DATA_W bits.
  - Localparam FILL_MAX = DEPTH.
  - Reset constants: RST_PTR = 0, RST_FILL = 0.
- One sub-module is natural: past_hist_mem.
  - DEPTH x DATA_W register array with one write port and one asynchronous read port.
  - Write enable = en & ~rst & ~clr.
- Pointer, fill counter, range check and output masking live in the top module.

Test Plan:
- Basic look-back: rst for 2 cycles, then en=1 with din=3,7,9 on 3 edges, then rd_ticks=1/2/3 -> past_out=9/7/3, past_valid=1, fill=3.
- Gating: capture din=5, then en=0 for 4 edges while din=12, then en=1 capturing din=1; rd_ticks=2 -> past_out=5. fill must not increment while en=0.
- Wrap, with DEPTH=4: capture 1,2,3,4,5,6 -> fill=4. rd_ticks=4 -> 3; rd_ticks=1 -> 6; rd_ticks=5 -> past_valid=0, past_out=0.
- Empty and illegal: after rst, rd_ticks=1 -> past_valid=0, past_out=0, past_changed=0. With fill=2, rd_ticks=0 -> past_valid=0.
- Flush priority: fill=3, then clr=1 and en=1 with din=8 on one edge -> fill=0, past_valid=0. Next capture of din=2 with rd_ticks=1 -> past_out=2.
- Change detect and reset mid-stream: last captured value 4, live din=4 -> past_changed=0; din=6 -> past_changed=1. Assert rst -> past_changed=0 and fill=0 on the following cycle.
